// File: rtl/arm_run_controller.sv
// Run controller for the ARM pipeline core.
// Sequences the core reset after a start request, latches the run mode,
// counts RUN cycles and ends the run on a halt request or when the cycle
// budget is used up. Every output comes straight from a register.
module arm_run_controller #(
    parameter int RST_HOLD   = 3,
    parameter int MAX_CYCLES = 750,
    parameter int CNT_W      = 16,
    parameter int MODE_W     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic [MODE_W-1:0] mode_in,
    output logic              core_rst,
    output logic [MODE_W-1:0] switch,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt
);

    // Hold counter only needs to reach RST_HOLD-1.
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic                core_rst_q,  core_rst_d;
    logic [MODE_W-1:0]   switch_q,    switch_d;
    logic                running_q,   running_d;
    logic                done_q,      done_d;
    logic                timeout_q,   timeout_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;

    // Next-state logic; output registers are derived from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        switch_d    = switch_q;
        timeout_d   = timeout_q;
        cycle_cnt_d = cycle_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A start here clears the previous run's status and latches the new mode.
                if (start) begin
                    state_d     = ST_HOLD;
                    switch_d    = mode_in;
                    cycle_cnt_d = {CNT_W{1'b0}};
                    timeout_d   = 1'b0;
                    hold_cnt_d  = {HOLD_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                // start and halt_req are deliberately ignored while the core is held.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                // The exit edge is counted too, so DONE reports elapsed RUN cycles.
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                if (halt_req) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b0;
                end else if (cycle_cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        core_rst_d = (state_d != ST_RUN);
        running_d  = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
    end

    // State and output registers; reset puts the core back into reset immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= {HOLD_W{1'b0}};
            core_rst_q  <= 1'b1;
            switch_q    <= {MODE_W{1'b0}};
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            core_rst_q  <= core_rst_d;
            switch_q    <= switch_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign core_rst  = core_rst_q;
    assign switch    = switch_q;
    assign running   = running_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
